game_anim_timebase: RTL and testbench

Timebase and motion generator for the dino game display path. It derives the 25 MHz pixel-rate clock enable and a 50 %-duty divided clock from the 100 MHz board clock. It also produces the two-frame dinosaur run-animation select and three independent asteroid position offsets that freeze on collision and clear on game restart. It sits between the board clock and the renderer, which adds the offsets to each sprite's base coordinates.

---
 rtl/game_anim_timebase.sv | 141 ++++++++++++++
 tb/tb_game_anim_timebase.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/game_anim_timebase.sv
// game_anim_timebase
// Timebase and motion generator for the dino game display path.
// A divide-by-CLK_DIV counter produces the pixel-rate enable and a 50 %-duty
// divided clock. Two pixel-rate counters drive the run-animation frame select
// and the asteroid step timer. Three asteroid offset pairs advance and wrap on
// each step, freeze while halt is high, and clear on restart.
//
// Ports:
//   clk          in   board clock, the only clock
//   reset        in   synchronous active-low reset
//   halt         in   collision freeze (active-high)
//   restart      in   game restart (active-high, synchronous)
//   asteroid_on  in   [2:0] per-asteroid enable
//   divided_clk  out  clk/CLK_DIV square wave (registered)
//   pix_ce       out  one-clk pulse every CLK_DIV clocks (registered)
//   runner       out  run-animation frame select
//   xmovN/ymovN  out  [9:0] asteroid N offsets, unsigned
module game_anim_timebase #(
  parameter int CLK_DIV  = 4,
  parameter int ANIM_DIV = 4_000_000,
  parameter int MOVE_DIV = 250_000,
  parameter int X_WRAP   = 540,
  parameter int Y_WRAP   = 380,
  parameter int DX0      = 1,
  parameter int DY0      = 1,
  parameter int DX1      = 1,
  parameter int DY1      = 2,
  parameter int DX2      = 2,
  parameter int DY2      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       halt,
  input  logic       restart,
  input  logic [2:0] asteroid_on,
  output logic       divided_clk,
  output logic       pix_ce,
  output logic       runner,
  output logic [9:0] xmov0,
  output logic [9:0] ymov0,
  output logic [9:0] xmov1,
  output logic [9:0] ymov1,
  output logic [9:0] xmov2,
  output logic [9:0] ymov2
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic [10:0] DX [3] = '{11'(DX0), 11'(DX1), 11'(DX2)};
  localparam logic [10:0] DY [3] = '{11'(DY0), 11'(DY1), 11'(DY2)};

  logic [DW-1:0] div_cnt;
  logic [AW-1:0] anim_cnt;
  logic [MW-1:0] move_cnt;
  logic [9:0]    x_q [3];
  logic [9:0]    y_q [3];
  logic          step;

  // Sum is formed 11 bits wide so a value near 1023 cannot wrap silently
  // before the limit compare; truncation happens only after the compare.
  function automatic logic [9:0] wrap_add(input logic [9:0]  v,
                                          input logic [10:0] d,
                                          input logic [10:0] lim);
    logic [10:0] s;
    s = {1'b0, v} + d;
    return (s >= lim) ? 10'd0 : s[9:0];
  endfunction

  // Step fires on the pixel tick that completes a MOVE_DIV period; a frozen
  // or restarting game never steps.
  assign step = pix_ce && !halt && !restart &&
                (move_cnt == MW'(MOVE_DIV - 1));

  // Clock divider. Both outputs are registered from the pre-edge count, so
  // pix_ce follows the cycle where div_cnt was CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt     <= '0;
      pix_ce      <= 1'b0;
      divided_clk <= 1'b0;
    end else begin
      div_cnt     <= (div_cnt == DW'(CLK_DIV - 1)) ? '0 : div_cnt + 1'b1;
      pix_ce      <= (div_cnt == DW'(CLK_DIV - 1));
      divided_clk <= (div_cnt >= DW'(CLK_DIV / 2));
    end
  end

  // Run animation keeps running through halt and restart; the renderer
  // swaps in the death sprite on its own.
  always_ff @(posedge clk) begin
    if (!reset) begin
      anim_cnt <= '0;
      runner   <= 1'b0;
    end else if (pix_ce) begin
      if (anim_cnt == AW'(ANIM_DIV - 1)) begin
        anim_cnt <= '0;
        runner   <= ~runner;
      end else begin
        anim_cnt <= anim_cnt + 1'b1;
      end
    end
  end

  // Motion timer holds its count during halt so release loses no step.
  always_ff @(posedge clk) begin
    if (!reset || restart) begin
      move_cnt <= '0;
    end else if (pix_ce && !halt) begin
      move_cnt <= (move_cnt == MW'(MOVE_DIV - 1)) ? '0 : move_cnt + 1'b1;
    end
  end

  // Per-asteroid offsets: restart > halt > disable > step > hold.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset || restart) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end else if (halt) begin
        x_q[i] <= x_q[i];
        y_q[i] <= y_q[i];
      end else if (!asteroid_on[i]) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end else if (step) begin
        x_q[i] <= wrap_add(x_q[i], DX[i], 11'(X_WRAP));
        y_q[i] <= wrap_add(y_q[i], DY[i], 11'(Y_WRAP));
      end
    end
  end

  assign xmov0 = x_q[0];
  assign ymov0 = y_q[0];
  assign xmov1 = x_q[1];
  assign ymov1 = y_q[1];
  assign xmov2 = x_q[2];
  assign ymov2 = y_q[2];

endmodule

// File: tb/tb_game_anim_timebase.sv
// tb_game_anim_timebase
// Bench for game_anim_timebase with short divider settings. A cycle model
// pushes the expected output word on every rising edge; the checker pops and
// compares on every falling edge. Directed steps add fixed-value checks for
// the wrap sequences, restart priority, enable clearing and mid-run reset.
module tb_game_anim_timebase;

  localparam int CLK_DIV  = 4;
  localparam int ANIM_DIV = 3;
  localparam int MOVE_DIV = 2;
  localparam int X_WRAP   = 5;
  localparam int Y_WRAP   = 4;
  localparam int W        = 63;

  // clock / reset
  logic clk = 1'b0;
  logic reset, halt, restart;
  logic [2:0] asteroid_on;
  always #5 clk = ~clk;

  logic       divided_clk, pix_ce, runner;
  logic [9:0] xmov0, ymov0, xmov1, ymov1, xmov2, ymov2;

  game_anim_timebase #(
    .CLK_DIV(CLK_DIV), .ANIM_DIV(ANIM_DIV), .MOVE_DIV(MOVE_DIV),
    .X_WRAP(X_WRAP), .Y_WRAP(Y_WRAP),
    .DX0(1), .DY0(1), .DX1(1), .DY1(2), .DX2(2), .DY2(1)
  ) dut (
    .clk(clk), .reset(reset), .halt(halt), .restart(restart),
    .asteroid_on(asteroid_on), .divided_clk(divided_clk), .pix_ce(pix_ce),
    .runner(runner), .xmov0(xmov0), .ymov0(ymov0), .xmov1(xmov1),
    .ymov1(ymov1), .xmov2(xmov2), .ymov2(ymov2)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard
  logic [W-1:0] exp_q[$];

  // Reference model, advanced on each rising edge from the driven inputs.
  int m_div = 0, m_anim = 0, m_move = 0;
  int m_pix = 0, m_dclk = 0, m_runner = 0;
  int m_x[3] = '{0, 0, 0};
  int m_y[3] = '{0, 0, 0};
  int m_dx[3] = '{1, 1, 2};
  int m_dy[3] = '{1, 2, 1};

  always @(posedge clk) begin
    int nx, ny, mstep;
    logic [W-1:0] e;
    if (reset !== 1'b1) begin
      m_div = 0; m_anim = 0; m_move = 0;
      m_pix = 0; m_dclk = 0; m_runner = 0;
      for (int i = 0; i < 3; i++) begin m_x[i] = 0; m_y[i] = 0; end
    end else begin
      mstep = (m_pix == 1 && !halt && !restart && m_move == MOVE_DIV - 1);
      // animation
      if (m_pix == 1) begin
        m_anim = m_anim + 1;
        if (m_anim == ANIM_DIV) begin m_anim = 0; m_runner = 1 - m_runner; end
      end
      // motion timer
      if (restart) m_move = 0;
      else if (!halt && m_pix == 1) m_move = (m_move + 1) % MOVE_DIV;
      // asteroids
      for (int i = 0; i < 3; i++) begin
        if (restart) begin m_x[i] = 0; m_y[i] = 0; end
        else if (halt) begin end
        else if (!asteroid_on[i]) begin m_x[i] = 0; m_y[i] = 0; end
        else if (mstep != 0) begin
          nx = m_x[i] + m_dx[i]; ny = m_y[i] + m_dy[i];
          m_x[i] = (nx >= X_WRAP) ? 0 : nx;
          m_y[i] = (ny >= Y_WRAP) ? 0 : ny;
        end
      end
      // divider
      m_pix  = (m_div == CLK_DIV - 1) ? 1 : 0;
      m_dclk = (m_div >= CLK_DIV / 2) ? 1 : 0;
      m_div  = (m_div + 1) % CLK_DIV;
    end
    e = {m_runner[0], m_dclk[0], m_pix[0],
         10'(m_x[0]), 10'(m_y[0]), 10'(m_x[1]), 10'(m_y[1]),
         10'(m_x[2]), 10'(m_y[2])};
    exp_q.push_back(e);
  end

  // Checker on the falling edge.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [2:0]   got_t;
    logic [59:0]  got_o;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got_t = {runner, divided_clk, pix_ce};
      got_o = {xmov0, ymov0, xmov1, ymov1, xmov2, ymov2};
      checks++;
      assert (got_t === e[62:60]) else begin
        errors++;
        $error("FAIL timing @%0t observed runner/dclk/pix=%b expected=%b",
               $time, got_t, e[62:60]);
      end
      checks++;
      assert (got_o === e[59:0]) else begin
        errors++;
        $error("FAIL offsets @%0t observed=%h expected=%h",
               $time, got_o, e[59:0]);
      end
    end
  end

  // driver
  task automatic step_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs,
                     input logic [9:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  int ex0[5] = '{1, 2, 3, 4, 0};
  int ey0[5] = '{1, 2, 3, 0, 1};
  int ey1[5] = '{2, 0, 2, 0, 2};
  int ex2[5] = '{2, 4, 0, 2, 4};
  int erun[5] = '{0, 1, 0, 0, 1};

  initial begin
    reset = 1'b0; halt = 1'b0; restart = 1'b0; asteroid_on = 3'b111;
    step_clk(5);
    chk("reset_pix", {9'd0, pix_ce}, 10'd0);
    chk("reset_x0", xmov0, 10'd0);
    reset = 1'b1;

    // Steps land on edges 9, 17, 25, ... after release.
    step_clk(9);
    for (int k = 0; k < 5; k++) begin
      chk("wrap_x0", xmov0, 10'(ex0[k]));
      chk("wrap_y0", ymov0, 10'(ey0[k]));
      chk("wrap_y1", ymov1, 10'(ey1[k]));
      chk("wrap_x2", xmov2, 10'(ex2[k]));
      chk("runner", {9'd0, runner}, 10'(erun[k]));
      if (k < 4) step_clk(8);
    end

    // halt mid-run
    step_clk(3);
    halt = 1'b1;
    step_clk(20);
    halt = 1'b0;
    step_clk(30);

    // restart beats halt
    halt = 1'b1; restart = 1'b1;
    step_clk(1);
    chk("restart_x0", xmov0, 10'd0);
    chk("restart_y2", ymov2, 10'd0);
    halt = 1'b0; restart = 1'b0;
    step_clk(23);

    // disabling asteroid 1
    asteroid_on = 3'b101;
    step_clk(1);
    chk("off_x1", xmov1, 10'd0);
    chk("off_y1", ymov1, 10'd0);
    step_clk(15);

    // one-clock reset mid-run
    reset = 1'b0; halt = 1'b1;
    step_clk(1);
    chk("midrst_dclk", {9'd0, divided_clk}, 10'd0);
    chk("midrst_runner", {9'd0, runner}, 10'd0);
    chk("midrst_x0", xmov0, 10'd0);
    chk("midrst_y2", ymov2, 10'd0);
    reset = 1'b1; halt = 1'b0; asteroid_on = 3'b111;

    // random phase
    for (int c = 0; c < 400; c++) begin
      halt    = ($urandom_range(0, 9) == 0);
      restart = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) asteroid_on = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 149) == 0) reset = 1'b0; else reset = 1'b1;
      step_clk(1);
    end
    reset = 1'b1; halt = 1'b0; restart = 1'b0;
    step_clk(4);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
